// File: rtl/alu_op_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer_if
// Command and response channels between a front end and alu_op_sequencer.
//
// Parameters
//   WIDTH  datapath width
//   RW     register index width
//
// Signals
//   cmd_valid/cmd_ready      command handshake
//   cmd_op                   ALU opcode
//   cmd_rd/cmd_ra/cmd_rb     destination and source registers
//   cmd_imm_sel/cmd_imm      select immediate as operand B / immediate value
//   rsp_valid/rsp_ready      response handshake
//   rsp_data/rsp_flags       result and {N,Z,C,V}
//   rsp_err                  illegal opcode, nothing written
//
// Modports: master = front end, slave = sequencer.
// -----------------------------------------------------------------------------
interface alu_op_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int RW    = 2
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [RW-1:0]    cmd_rd;
    logic [RW-1:0]    cmd_ra;
    logic [RW-1:0]    cmd_rb;
    logic             cmd_imm_sel;
    logic [WIDTH-1:0] cmd_imm;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [3:0]       rsp_flags;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm_sel, cmd_imm, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_flags, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm_sel, cmd_imm, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_flags, rsp_err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Owns an external combinational ALU and a small register file. Accepts one
// command at a time, reads operands at accept, drives the ALU for one cycle
// (EXEC), writes the result and flags back, and returns a response.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   bus                command/response channels (alu_op_sequencer_if.slave)
//   alu_a, alu_b       ALU operands
//   alu_flag_in        ALU carry-in, the stored C flag
//   alu_control        ALU opcode
//   alu_result         ALU result
//   alu_flags          ALU flags {N,Z,C,V}
//   dbg_addr/dbg_data  combinational register file read port
//
// Build option: define ALU_SEQ_MUL_EN to make opcode 0xF a multi-cycle
// shift-and-add multiply (MULT state) built on the ALU's ADD. Without it,
// 0xF is an illegal opcode.
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter  int WIDTH = 4,
    parameter  int NREGS = 4,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_op_sequencer_if.slave    bus,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic                 alu_flag_in,
    output logic [3:0]           alu_control,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic [3:0]           alu_flags,
    input  logic [RW-1:0]        dbg_addr,
    output logic [WIDTH-1:0]     dbg_data
);
    localparam logic [3:0] OP_LAST = 4'd9;   // highest ALU-native opcode
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'hF;
    localparam int         CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
`ifdef ALU_SEQ_MUL_EN
        , MULT = 2'd3
`endif
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] regs [NREGS];
    logic [3:0]       flag_reg;
    logic [3:0]       op_reg;
    logic [RW-1:0]    rd_reg;
    logic [WIDTH-1:0] alu_a_reg, alu_b_reg;
    logic [3:0]       alu_ctl_reg;
    logic             alu_cin_reg;
    logic [WIDTH-1:0] rsp_data_reg;
    logic [3:0]       rsp_flags_reg;
    logic             rsp_err_reg;

    logic             accept;
    logic [WIDTH-1:0] src_a, src_b;
    logic             done;       // last execute cycle of this command
    logic             wr_en;      // commit result to regfile and flag reg
    logic [WIDTH-1:0] wr_data;
    logic [3:0]       wr_flags;

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] mul_a_reg;  // multiplier; bit cnt_reg selects this step
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] acc_next;
    logic             mul_last;

    // alu_a_reg is the accumulator, alu_b_reg holds B<<cnt; the ALU sum is
    // kept only when the current multiplier bit is set.
    assign acc_next = mul_a_reg[cnt_reg] ? alu_result : alu_a_reg;
    assign mul_last = (cnt_reg == CW'(WIDTH - 1));
`endif

    assign accept = bus.cmd_valid && (state_reg == IDLE);
    assign src_a  = regs[bus.cmd_ra];
    assign src_b  = bus.cmd_imm_sel ? bus.cmd_imm : regs[bus.cmd_rb];

    assign bus.cmd_ready = (state_reg == IDLE);
    assign bus.rsp_valid = (state_reg == RESP);
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.rsp_flags = rsp_flags_reg;
    assign bus.rsp_err   = rsp_err_reg;

    assign alu_a       = alu_a_reg;
    assign alu_b       = alu_b_reg;
    assign alu_control = alu_ctl_reg;
    assign alu_flag_in = alu_cin_reg;
    assign dbg_data    = regs[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        done       = 1'b0;
        wr_en      = 1'b0;
        wr_data    = alu_result;
        wr_flags   = alu_flags;
        case (state_reg)
            IDLE: begin
                if (accept) begin
`ifdef ALU_SEQ_MUL_EN
                    state_next = (bus.cmd_op == OP_MUL) ? MULT : EXEC;
`else
                    state_next = EXEC;
`endif
                end
            end
            EXEC: begin
                done       = 1'b1;
                wr_en      = (op_reg <= OP_LAST);
                state_next = RESP;
            end
`ifdef ALU_SEQ_MUL_EN
            MULT: begin
                if (mul_last) begin
                    done       = 1'b1;
                    wr_en      = 1'b1;
                    wr_data    = acc_next;
                    wr_flags   = {acc_next[WIDTH-1], (acc_next == '0), 2'b00};
                    state_next = RESP;
                end
            end
`endif
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            flag_reg      <= '0;
            op_reg        <= '0;
            rd_reg        <= '0;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            alu_ctl_reg   <= '0;
            alu_cin_reg   <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_flags_reg <= '0;
            rsp_err_reg   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mul_a_reg     <= '0;
            cnt_reg       <= '0;
`endif
        end else begin
            // Operands are captured at accept, so same-register sources see
            // the value before this command's write-back.
            if (accept) begin
                op_reg      <= bus.cmd_op;
                rd_reg      <= bus.cmd_rd;
                alu_a_reg   <= src_a;
                alu_b_reg   <= src_b;
                alu_ctl_reg <= bus.cmd_op;
                alu_cin_reg <= flag_reg[1];
`ifdef ALU_SEQ_MUL_EN
                mul_a_reg   <= src_a;
                cnt_reg     <= '0;
                if (bus.cmd_op == OP_MUL) begin
                    alu_a_reg   <= '0;
                    alu_ctl_reg <= OP_ADD;
                    alu_cin_reg <= 1'b0;
                end
`endif
            end
`ifdef ALU_SEQ_MUL_EN
            if (state_reg == MULT && !mul_last) begin
                alu_a_reg <= acc_next;
                alu_b_reg <= alu_b_reg << 1;
                cnt_reg   <= cnt_reg + 1'b1;
            end
`endif
            if (wr_en) begin
                regs[rd_reg] <= wr_data;
                flag_reg     <= wr_flags;
            end
            if (done) begin
                rsp_err_reg   <= !wr_en;
                rsp_data_reg  <= wr_en ? wr_data : '0;
                rsp_flags_reg <= wr_en ? wr_flags : 4'b0000;
            end
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
    localparam int WIDTH = 4;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam int MUL_LAT = WIDTH + 1;

    typedef struct {
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] ra;
        logic [1:0] rb;
        logic       imm_sel;
        logic [3:0] imm;
        int         bp;
    } cmd_t;

    typedef struct {
        logic       err;
        logic [3:0] data;
        logic [3:0] flags;
        logic       cin;
        int         lat;
        logic [3:0] alu_a;
        logic [3:0] alu_b;
        logic [3:0] ctl;
    } exp_t;

    typedef struct {
        cmd_t c;
        exp_t e;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] alu_a, alu_b, alu_control, alu_result, alu_flags;
    logic       alu_flag_in;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] m_regs [4];
    logic [3:0] m_flags;
    vec_t       tab [$];

    alu_op_sequencer_if #(.WIDTH(WIDTH), .RW(2)) bus ();

    alu_op_sequencer #(.WIDTH(WIDTH), .NREGS(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_flag_in (alu_flag_in),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_flags   (alu_flags),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 4-bit ALU: returns {result, N, Z, C, V}.
    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [3:0] a,
                                          input logic [3:0] b, input logic cin);
        logic [4:0] t;
        logic [3:0] r;
        logic       c, v;
        t = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: begin
                t = {1'b0, a} + {1'b0, b} + {4'b0, cin};
                r = t[3:0]; c = t[4]; v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            4'd3: begin t = {1'b0, a} + 5'd1; r = t[3:0]; c = t[4]; v = (a == 4'h7); end
            4'd4: begin t = {1'b0, a} - 5'd1; r = t[3:0]; c = t[4]; v = (a == 4'h8); end
            4'd5: r = ~a;
            4'd6: begin
                t = {1'b0, a} - {1'b0, b};
                r = t[3:0]; c = t[4]; v = (a[3] != b[3]) && (r[3] != a[3]);
            end
            4'd7: r = a ^ b;
            4'd8: begin r = {a[2:0], 1'b0}; c = a[3]; end
            4'd9: begin r = {1'b0, a[3:1]}; c = a[0]; end
            default: r = '0;
        endcase
        return {r, r[3], (r == 4'd0), c, v};
    endfunction

    assign {alu_result, alu_flags} = alu_fn(alu_control, alu_a, alu_b, alu_flag_in);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        m_flags = '0;
    endtask

    // Command-level reference: result from operands read before write-back,
    // flags only committed by legal operations.
    task automatic model_exec(input cmd_t c, output exp_t e);
        logic [3:0] a, b;
        logic [7:0] rf, p;
        a = m_regs[c.ra];
        b = c.imm_sel ? c.imm : m_regs[c.rb];
        e.lat = 2; e.alu_a = a; e.alu_b = b; e.ctl = c.op; e.cin = m_flags[1];
        e.err = 1'b0; e.data = '0; e.flags = '0;
        if (c.op <= 4'd9) begin
            rf = alu_fn(c.op, a, b, m_flags[1]);
            e.data = rf[7:4]; e.flags = rf[3:0];
            m_regs[c.rd] = e.data; m_flags = e.flags;
        end else if (c.op == 4'hF && MUL_EN) begin
            p = {4'b0, a} * {4'b0, b};
            e.data = p[3:0]; e.flags = {p[3], (p[3:0] == 4'd0), 2'b00};
            e.lat = MUL_LAT; e.alu_a = '0; e.ctl = 4'd2; e.cin = 1'b0;
            m_regs[c.rd] = e.data; m_flags = e.flags;
        end else begin
            e.err = 1'b1;
        end
    endtask

    task automatic run_cmd(input int idx, input cmd_t c, input exp_t e);
        int n;
        int lat;
        bus.cmd_op = c.op; bus.cmd_rd = c.rd; bus.cmd_ra = c.ra; bus.cmd_rb = c.rb;
        bus.cmd_imm_sel = c.imm_sel; bus.cmd_imm = c.imm; bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
        if (!bus.cmd_ready) begin
            bus.cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        lat = 1;
        chk("busy_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("exec_alu_control", 32'(alu_control), 32'(e.ctl));
        chk("exec_alu_a", 32'(alu_a), 32'(e.alu_a));
        chk("exec_alu_b", 32'(alu_b), 32'(e.alu_b));
        chk("exec_alu_flag_in", 32'(alu_flag_in), 32'(e.cin));
        while (!bus.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(e.lat));
        if (!bus.rsp_valid) return;
        for (int k = 0; k <= c.bp; k++) begin
            chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
            chk("rsp_flags", 32'(bus.rsp_flags), 32'(e.flags));
            chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            chk("resp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            if (k < c.bp) @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
        chk("cmd_ready_back", 32'(bus.cmd_ready), 32'd1);
        dbg_addr = c.rd;
        #1;
        chk("dbg_rd", 32'(dbg_data), 32'(m_regs[c.rd]));
        $display("txn %0d op=%h rd=%0d ra=%0d rb=%0d isel=%0d imm=%h -> data=%h flags=%b err=%0d lat=%0d",
                 idx, c.op, c.rd, c.ra, c.rb, c.imm_sel, c.imm,
                 bus.rsp_data, bus.rsp_flags, bus.rsp_err, lat);
    endtask

    task automatic add_vec(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                           input logic [1:0] rb, input logic isel, input logic [3:0] imm,
                           input int bp, input logic err, input logic [3:0] data,
                           input logic [3:0] flags, input logic cin, input int lat);
        vec_t v;
        v.c.op = op; v.c.rd = rd; v.c.ra = ra; v.c.rb = rb;
        v.c.imm_sel = isel; v.c.imm = imm; v.c.bp = bp;
        v.e.err = err; v.e.data = data; v.e.flags = flags; v.e.cin = cin; v.e.lat = lat;
        v.e.alu_a = '0; v.e.alu_b = '0; v.e.ctl = '0;
        tab.push_back(v);
    endtask

    task automatic check_all_dbg_zero(input string name);
        for (int a = 0; a < 4; a++) begin
            dbg_addr = 2'(a);
            #1;
            chk(name, 32'(dbg_data), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        cmd_t c;
        rst_n = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_rd = '0; bus.cmd_ra = '0;
        bus.cmd_rb = '0; bus.cmd_imm_sel = 1'b0; bus.cmd_imm = '0; bus.rsp_ready = 1'b0;
        dbg_addr = '0;
        model_reset();

        // Reset asserted mid-cycle acts immediately.
        #2 rst_n = 1'b0;
        #1;
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("reset_rsp_flags", 32'(bus.rsp_flags), 32'd0);
        chk("reset_alu_a", 32'(alu_a), 32'd0);
        chk("reset_alu_control", 32'(alu_control), 32'd0);
        check_all_dbg_zero("reset_dbg");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Directed table: {op, rd, ra, rb, imm_sel, imm, backpressure, err, data, flags, cin, latency}
        add_vec(4'd1, 2'd1, 2'd0, 2'd0, 1'b1, 4'h1, 0, 1'b0, 4'h1, 4'b0000, 1'b0, 2);
        add_vec(4'd1, 2'd2, 2'd0, 2'd0, 1'b1, 4'h2, 0, 1'b0, 4'h2, 4'b0000, 1'b0, 2);
        add_vec(4'd2, 2'd3, 2'd1, 2'd2, 1'b0, 4'h0, 5, 1'b0, 4'h3, 4'b0000, 1'b0, 2);
        add_vec(4'd1, 2'd1, 2'd0, 2'd0, 1'b1, 4'hF, 0, 1'b0, 4'hF, 4'b1000, 1'b0, 2);
        add_vec(4'd2, 2'd2, 2'd1, 2'd0, 1'b1, 4'h1, 0, 1'b0, 4'h0, 4'b0110, 1'b0, 2);
        add_vec(4'd2, 2'd3, 2'd0, 2'd0, 1'b1, 4'h0, 0, 1'b0, 4'h1, 4'b0000, 1'b1, 2);
        add_vec(4'd1, 2'd2, 2'd0, 2'd0, 1'b1, 4'h5, 0, 1'b0, 4'h5, 4'b0000, 1'b0, 2);
        add_vec(4'd2, 2'd0, 2'd1, 2'd0, 1'b1, 4'h1, 0, 1'b0, 4'h0, 4'b0110, 1'b0, 2);
        add_vec(4'hB, 2'd2, 2'd1, 2'd0, 1'b1, 4'h0, 1, 1'b1, 4'h0, 4'b0000, 1'b1, 2);
        add_vec(4'd2, 2'd3, 2'd0, 2'd0, 1'b1, 4'h0, 0, 1'b0, 4'h1, 4'b0000, 1'b1, 2);
        add_vec(4'd1, 2'd1, 2'd0, 2'd0, 1'b1, 4'h3, 0, 1'b0, 4'h3, 4'b0000, 1'b0, 2);
        add_vec(4'hF, 2'd2, 2'd1, 2'd0, 1'b1, 4'h5, 0, !MUL_EN, MUL_EN ? 4'hF : 4'h0,
                MUL_EN ? 4'b1000 : 4'b0000, 1'b0, MUL_EN ? MUL_LAT : 2);
        add_vec(4'd1, 2'd3, 2'd0, 2'd0, 1'b1, 4'h6, 0, 1'b0, 4'h6, 4'b0000, 1'b0, 2);
        add_vec(4'hF, 2'd2, 2'd1, 2'd3, 1'b0, 4'h0, 2, !MUL_EN, MUL_EN ? 4'h2 : 4'h0,
                4'b0000, 1'b0, MUL_EN ? MUL_LAT : 2);
        add_vec(4'd2, 2'd2, 2'd2, 2'd2, 1'b0, 4'h0, 0, 1'b0, MUL_EN ? 4'h4 : 4'hA,
                MUL_EN ? 4'b0000 : 4'b1001, 1'b0, 2);

        for (int i = 0; i < tab.size(); i++) begin
            model_exec(tab[i].c, e);
            e.err = tab[i].e.err; e.data = tab[i].e.data; e.flags = tab[i].e.flags;
            e.cin = tab[i].e.cin; e.lat = tab[i].e.lat;
            run_cmd(i, tab[i].c, e);
        end

        // Reset while a command is executing: it is dropped with no response.
        bus.cmd_op = 4'd1; bus.cmd_rd = 2'd1; bus.cmd_ra = 2'd0; bus.cmd_rb = 2'd0;
        bus.cmd_imm_sel = 1'b1; bus.cmd_imm = 4'h7; bus.cmd_valid = 1'b1;
        @(posedge clk);
        #3;
        bus.cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midreset_alu_a", 32'(alu_a), 32'd0);
        check_all_dbg_zero("midreset_dbg");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        chk("midreset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        repeat (3) @(negedge clk);
        chk("midreset_no_rsp", 32'(bus.rsp_valid), 32'd0);

        // Random commands against the reference model.
        for (int i = 0; i < 40; i++) begin
            c.op = 4'($urandom_range(0, 15));
            c.rd = 2'($urandom_range(0, 3));
            c.ra = 2'($urandom_range(0, 3));
            c.rb = 2'($urandom_range(0, 3));
            c.imm_sel = 1'($urandom_range(0, 1));
            c.imm = 4'($urandom_range(0, 15));
            c.bp = $urandom_range(0, 3);
            model_exec(c, e);
            run_cmd(100 + i, c, e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
